// File: rtl/flag_seq_pkg.sv
// rtl/flag_seq_pkg.sv - shared types, constants and decode helpers for flag_seq
// Holds the FSM state enum, flag bit positions, condition codes and op_code class decode.
package flag_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    COND = 2'd2
  } state_t;

  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  localparam logic [3:0] CC_ALWAYS = 4'b0000;
  localparam logic [3:0] CC_Z      = 4'b0001;
  localparam logic [3:0] CC_NZ     = 4'b0010;
  localparam logic [3:0] CC_C      = 4'b0011;
  localparam logic [3:0] CC_NC     = 4'b0100;
  localparam logic [3:0] CC_S      = 4'b0101;
  localparam logic [3:0] CC_NS     = 4'b0110;
  localparam logic [3:0] CC_O      = 4'b0111;
  localparam logic [3:0] CC_NO     = 4'b1000;
  localparam logic [3:0] CC_SNEO   = 4'b1001;
  localparam logic [3:0] CC_SEQO   = 4'b1010;

  localparam logic [3:0] MASK_ZCSO = 4'b1111;
  localparam logic [3:0] MASK_ZCS  = 4'b0111;
  localparam logic [3:0] MASK_ZS   = 4'b0101;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  function automatic logic [3:0] op_mask(input logic [4:0] op);
    logic [3:0] m;
    case (op) inside
      5'b00000, 5'b00001, 5'b00011,
      5'b00100, 5'b00101, 5'b00110:           m = MASK_ZCSO;
      5'b01000, 5'b01001:                     m = MASK_ZCS;
      5'b10001, 5'b10010, [5'b10100:5'b11110]: m = MASK_ZS;
      default:                                m = MASK_NONE;
    endcase
    return m;
  endfunction

  // Codes 1011..1111 are reserved and always evaluate false.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] fl);
    logic t;
    case (cc)
      CC_ALWAYS: t = 1'b1;
      CC_Z:      t = fl[FLAG_Z];
      CC_NZ:     t = !fl[FLAG_Z];
      CC_C:      t = fl[FLAG_C];
      CC_NC:     t = !fl[FLAG_C];
      CC_S:      t = fl[FLAG_S];
      CC_NS:     t = !fl[FLAG_S];
      CC_O:      t = fl[FLAG_O];
      CC_NO:     t = !fl[FLAG_O];
      CC_SNEO:   t = fl[FLAG_S] != fl[FLAG_O];
      CC_SEQO:   t = fl[FLAG_S] == fl[FLAG_O];
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/flag_store.sv
// rtl/flag_store.sv - 4-bit flag register with per-bit write enable
// Asynchronous active-high reset clears all flags.
module flag_store
  import flag_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [FLAG_W-1:0] i_we,
  input  logic [FLAG_W-1:0] i_d,
  output logic [FLAG_W-1:0] o_q
);

  logic [FLAG_W-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (i_we[i]) r_q[i] <= i_d[i];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/flag_seq.sv
// rtl/flag_seq.sv - ALU flag sequencer: op issue, masked flag commit, condition queries
// Optional ALU timeout is enabled by defining FLAG_SEQ_TIMEOUT_EN.
module flag_seq
  import flag_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [4:0] op_code,
  output logic       op_ready,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_s,
  input  logic       alu_o,
  output logic [3:0] flags,
  output logic [3:0] flag_we,
  input  logic       cond_req,
  input  logic [3:0] cond_code,
  output logic       cond_valid,
  output logic       cond_taken,
  output logic       busy,
  output logic       err_timeout
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op_code;
  logic       r_first;
  logic       r_cond_valid;
  logic       r_cond_taken;
  logic       w_op_acc;
  logic       w_cond_acc;
  logic       w_done;
  logic       w_timeout;
  logic [3:0] w_alu_flags;

  assign w_alu_flags = {alu_o, alu_s, alu_c, alu_z};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_op_code    <= '0;
      r_first      <= 1'b0;
      r_cond_valid <= 1'b0;
      r_cond_taken <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_first      <= w_op_acc;
      r_cond_valid <= w_cond_acc;
      if (w_op_acc)   r_op_code    <= op_code;
      if (w_cond_acc) r_cond_taken <= cond_eval(cond_code, flags);
    end
  end

  // Queries are only taken in IDLE, so they always see fully committed flags.
  always_comb begin
    w_next     = r_state;
    w_op_acc   = 1'b0;
    w_cond_acc = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          w_op_acc = 1'b1;
          w_next   = EXEC;
        end else if (cond_req) begin
          w_cond_acc = 1'b1;
          w_next     = COND;
        end
      end
      EXEC: begin
        if (alu_done) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      COND:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef FLAG_SEQ_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_op_acc) begin
      r_tmo_cnt <= '0;
    end else if (r_state == EXEC) begin
      r_tmo_cnt <= r_tmo_cnt + 4'd1;
    end
  end

  // Fires in the 16th EXEC cycle unless the ALU finishes in that same cycle.
  assign w_timeout = (r_state == EXEC) && !alu_done && (r_tmo_cnt == 4'hF);
`else
  assign w_timeout = 1'b0;
`endif

  flag_store u_flag_store (
    .clock (clock),
    .reset (reset),
    .i_we  (flag_we),
    .i_d   (w_alu_flags),
    .o_q   (flags)
  );

  assign flag_we     = w_done ? op_mask(r_op_code) : MASK_NONE;
  assign op_ready    = (r_state == IDLE);
  assign alu_start   = (r_state == EXEC) && r_first;
  assign busy        = (r_state != IDLE);
  assign cond_valid  = r_cond_valid;
  assign cond_taken  = r_cond_taken;
  assign err_timeout = w_timeout;

endmodule
